sub_osc_seq: RTL and testbench
==============================

SUB_OSC_SEQ -- requirements
Module: sub_osc_seq

Interface
REQ-001 Parameter SYNC_STG, default 2, number of synchronizer flops on SUBCKIN (minimum 2).
REQ-002 Parameter STOP_WAIT, default 4, CLK cycles between clock-enable drop and XTSTOP assertion (range 1..15).
REQ-003 Parameter TO_LIMIT, default 65535, CLK cycles without a sub-clock edge before timeout (16-bit).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: CLK in 1, main system clock; RESET in 1, synchronous active-high reset.
REQ-005 OSCSELS in 1: OSC mode selected (H); when L, the sequencer is held in OFF.
REQ-006 START_REQ in 1: single-cycle pulse requesting sub-OSC start.
REQ-007 STOP_REQ in 1: single-cycle pulse requesting sub-OSC stop.
REQ-008 STABSEL in 2: stabilization edge count select: 0=256, 1=1024, 2=4096, 3=16384.
REQ-009 RTCREQ in 1: RTC wants the sub clock (level).
REQ-010 SUBCKIN in 1: asynchronous sub-clock from the XT pin path.
REQ-011 XTSTOP out 1: oscillator stop (H).
REQ-012 CPUCLKEN out 1: CPU sub-clock enable.
REQ-013 RTCCLKEN out 1: RTC sub-clock enable.
REQ-014 STABLE out 1: oscillator stabilized (H in RUN only).
REQ-015 BUSY out 1: sequencer in START, STAB or STOPPING.
REQ-016 TOERR out 1: sticky timeout flag (present only with the macro).

Function
REQ-017 SUBCKIN SHALL pass through SYNC_STG flops plus one edge-detect flop; a rising edge is one CLK-cycle pulse sub_rise.
REQ-018 States: OFF, START, STAB, RUN, STOPPING; the encoding is held in the package.
REQ-019 OFF: XTSTOP=1, all enables 0; START_REQ with OSCSELS=1 moves to START next cycle.
REQ-020 START: XTSTOP=0, edge counter cleared, STABSEL latched; the next cycle moves to STAB.
REQ-021 STAB: the 15-bit counter increments on each sub_rise; when count reaches the latched limit minus 1 and sub_rise occurs, the state moves to RUN.
REQ-022 RUN: STABLE=1, CPUCLKEN=1, RTCCLKEN=RTCREQ (registered, 1-cycle latency).
REQ-023 STOP_REQ in START, STAB or RUN moves to STOPPING: enables drop in the same transition, XTSTOP stays 0 for STOP_WAIT cycles, then the state moves to OFF with XTSTOP=1.
REQ-024 START_REQ and STOP_REQ in the same cycle: STOP_REQ wins; START_REQ in START, STAB, RUN or STOPPING is ignored.
REQ-025 OSCSELS falling in any state forces OFF next cycle and clears counters.
REQ-026 STABSEL changes after START are ignored until the next START.
REQ-027 All outputs SHALL be registered; no combinational input-to-output path is permitted.

Reset
REQ-028 On RESET=1 at a CLK edge: state=OFF, XTSTOP=1, CPUCLKEN=0, RTCCLKEN=0, STABLE=0, BUSY=0, TOERR=0, counters and synchronizer cleared.
REQ-029 RESET mid-sequence (any state) SHALL take effect on the same edge, and reset SHALL override all requests.

Configuration
REQ-030 Macro SUBOSC_TIMEOUT_EN: when defined, a 16-bit CLK counter clears on sub_rise or on state change; reaching TO_LIMIT in STAB or RUN sets TOERR (sticky until RESET) and forces STOPPING.
REQ-031 Without SUBOSC_TIMEOUT_EN, the TOERR port is absent and STAB waits indefinitely.

Structure
REQ-032 Shared package sub_osc_pkg SHALL hold the state enum, the STABSEL-to-limit constant table (256/1024/4096/16384) and the default parameter constants.
REQ-033 One sub-module, sub_osc_sync (synchronizer plus rising-edge detector), SHALL be instantiated once.

Verification
REQ-034 Reset, then START_REQ with STABSEL=0 and SUBCKIN toggling every 8 CLK cycles -> XTSTOP=0 one cycle after the request; STABLE and CPUCLKEN rise after the 256th sync'd edge plus 1 cycle.
REQ-035 In RUN, toggle RTCREQ 0->1->0 -> RTCCLKEN follows with 1-cycle latency each time; CPUCLKEN stays 1.
REQ-036 STOP_REQ in RUN with STOP_WAIT=4 -> enables 0 next cycle, XTSTOP=1 exactly 4 cycles later, BUSY high throughout.
REQ-037 START_REQ and STOP_REQ in the same cycle while in STAB -> STOPPING; a START_REQ in STOPPING is ignored and the state ends in OFF.
REQ-038 OSCSELS deasserted mid-STAB at count 100 -> OFF next cycle; a new START restarts counting from 0.
REQ-039 With SUBOSC_TIMEOUT_EN and TO_LIMIT=1000, SUBCKIN held static in STAB -> TOERR=1 at cycle 1000 followed by the STOPPING->OFF sequence; TOERR persists until RESET.

Source files
------------

// File: rtl/sub_osc_pkg.sv
// sub_osc_pkg: shared state encoding, stabilization limit table and parameter defaults for sub_osc_seq
package sub_osc_pkg;
    typedef enum logic [2:0] {ST_OFF, ST_START, ST_STAB, ST_RUN, ST_STOPPING} state_e;
    localparam int SYNC_STG_DEF = 2;
    localparam int STOP_WAIT_DEF = 4;
    localparam int TO_LIMIT_DEF = 65535;
    localparam logic [14:0] STAB_LIM [4] = '{15'd256, 15'd1024, 15'd4096, 15'd16384};
endpackage

// File: rtl/sub_osc_seq_if.sv
// sub_osc_seq_if: control/status bundle of the sub-oscillator sequencer; TOERR exists only with SUBOSC_TIMEOUT_EN
interface sub_osc_seq_if;
    logic       OSCSELS;
    logic       START_REQ;
    logic       STOP_REQ;
    logic [1:0] STABSEL;
    logic       RTCREQ;
    logic       SUBCKIN;
    logic       XTSTOP;
    logic       CPUCLKEN;
    logic       RTCCLKEN;
    logic       STABLE;
    logic       BUSY;
`ifdef SUBOSC_TIMEOUT_EN
    logic       TOERR;
    modport master (output OSCSELS, START_REQ, STOP_REQ, STABSEL, RTCREQ, SUBCKIN,
                    input XTSTOP, CPUCLKEN, RTCCLKEN, STABLE, BUSY, TOERR);
    modport slave (input OSCSELS, START_REQ, STOP_REQ, STABSEL, RTCREQ, SUBCKIN,
                   output XTSTOP, CPUCLKEN, RTCCLKEN, STABLE, BUSY, TOERR);
`else
    modport master (output OSCSELS, START_REQ, STOP_REQ, STABSEL, RTCREQ, SUBCKIN,
                    input XTSTOP, CPUCLKEN, RTCCLKEN, STABLE, BUSY);
    modport slave (input OSCSELS, START_REQ, STOP_REQ, STABSEL, RTCREQ, SUBCKIN,
                   output XTSTOP, CPUCLKEN, RTCCLKEN, STABLE, BUSY);
`endif
endinterface

// File: rtl/sub_osc_sync.sv
// sub_osc_sync: SYNC_STG-flop synchronizer for the async sub clock plus a one-cycle rising-edge pulse
module sub_osc_sync
    import sub_osc_pkg::*;
#(
    parameter int SYNC_STG = SYNC_STG_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic sub_ck,
    output logic sub_rise
);
    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic edge_q, edge_d;
    always_comb begin
        sync_d = {sync_q[SYNC_STG-2:0], sub_ck};
        edge_d = sync_q[SYNC_STG-1];
    end
    assign sub_rise = sync_q[SYNC_STG-1] & ~edge_q;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end
endmodule

// File: rtl/sub_osc_seq.sv
// sub_osc_seq: sub-oscillator start/stabilize/run/stop sequencer with registered outputs.
// Optional SUBOSC_TIMEOUT_EN adds a missing-edge watchdog with sticky TOERR.
module sub_osc_seq
    import sub_osc_pkg::*;
#(
    parameter int SYNC_STG  = SYNC_STG_DEF,
    parameter int STOP_WAIT = STOP_WAIT_DEF,
    parameter int TO_LIMIT  = TO_LIMIT_DEF
) (
    input logic           CLK,
    input logic           RESET,
    sub_osc_seq_if.slave  bus
);
    state_e state_q, state_d;
    logic [14:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] wait_q, wait_d;
    logic xtstop_q, xtstop_d, cpuen_q, cpuen_d, rtcen_q, rtcen_d, stable_q, stable_d, busy_q, busy_d;
    logic sub_rise, to_hit, last_edge;

    sub_osc_sync #(.SYNC_STG(SYNC_STG)) u_sync (
        .CLK(CLK), .RESET(RESET), .sub_ck(bus.SUBCKIN), .sub_rise(sub_rise)
    );

`ifdef SUBOSC_TIMEOUT_EN
    logic [15:0] to_q, to_d;
    logic toerr_q, toerr_d;
    assign to_hit = (state_q == ST_STAB || state_q == ST_RUN) && to_q == 16'(TO_LIMIT - 1);
    always_comb begin
        to_d = (sub_rise || state_d != state_q) ? '0 : to_q + 16'd1;
        toerr_d = toerr_q | to_hit;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            to_q <= '0;
            toerr_q <= 1'b0;
        end else begin
            to_q <= to_d;
            toerr_q <= toerr_d;
        end
    end
    assign bus.TOERR = toerr_q;
`else
    assign to_hit = 1'b0;
`endif

    assign last_edge = sub_rise && cnt_q == STAB_LIM[sel_q] - 15'd1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_OFF;
            cnt_q <= '0;
            sel_q <= '0;
            wait_q <= '0;
            xtstop_q <= 1'b1;
            cpuen_q <= 1'b0;
            rtcen_q <= 1'b0;
            stable_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            wait_q <= wait_d;
            xtstop_q <= xtstop_d;
            cpuen_q <= cpuen_d;
            rtcen_q <= rtcen_d;
            stable_q <= stable_d;
            busy_q <= busy_d;
        end
    end

    // STOP_REQ beats START_REQ; watchdog and OSCSELS loss override everything else
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF:      state_d = (bus.START_REQ && !bus.STOP_REQ) ? ST_START : ST_OFF;
            ST_START:    state_d = bus.STOP_REQ ? ST_STOPPING : ST_STAB;
            ST_STAB:     state_d = bus.STOP_REQ ? ST_STOPPING : last_edge ? ST_RUN : ST_STAB;
            ST_RUN:      state_d = bus.STOP_REQ ? ST_STOPPING : ST_RUN;
            ST_STOPPING: state_d = wait_q == 4'(STOP_WAIT - 1) ? ST_OFF : ST_STOPPING;
            default:     state_d = ST_OFF;
        endcase
        if (to_hit) state_d = ST_STOPPING;
        if (!bus.OSCSELS) state_d = ST_OFF;
    end

    always_comb begin
        cnt_d = state_d != ST_STAB ? '0 : (sub_rise && state_q == ST_STAB) ? cnt_q + 15'd1 : cnt_q;
        sel_d = state_d == ST_START ? bus.STABSEL : sel_q;
        wait_d = state_q == ST_STOPPING ? wait_q + 4'd1 : '0;
        xtstop_d = state_d == ST_OFF;
        cpuen_d = state_d == ST_RUN;
        rtcen_d = state_d == ST_RUN && bus.RTCREQ;
        stable_d = state_d == ST_RUN;
        busy_d = state_d == ST_START || state_d == ST_STAB || state_d == ST_STOPPING;
    end

    assign bus.XTSTOP = xtstop_q;
    assign bus.CPUCLKEN = cpuen_q;
    assign bus.RTCCLKEN = rtcen_q;
    assign bus.STABLE = stable_q;
    assign bus.BUSY = busy_q;
endmodule

// File: tb/tb_sub_osc_seq.sv
// tb_sub_osc_seq: directed bench for sub_osc_seq; timeout checks compile in with SUBOSC_TIMEOUT_EN
module tb_sub_osc_seq;
`ifdef SUBOSC_TIMEOUT_EN
    localparam int TL = 1000;
`else
    localparam int TL = 65535;
`endif
    logic CLK, RESET;
    int tests = 0, fails = 0;
    sub_osc_seq_if bus ();

    sub_osc_seq #(.SYNC_STG(2), .STOP_WAIT(4), .TO_LIMIT(TL)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic sub_edges(input int n);
        repeat (n) begin
            bus.SUBCKIN = 1'b1;
            tick(8);
            bus.SUBCKIN = 1'b0;
            tick(8);
        end
    endtask

    task automatic start_pulse();
        bus.START_REQ = 1'b1;
        tick(1);
        bus.START_REQ = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        bus.OSCSELS = 1'b1;
        bus.START_REQ = 1'b0;
        bus.STOP_REQ = 1'b0;
        bus.STABSEL = 2'd0;
        bus.RTCREQ = 1'b0;
        bus.SUBCKIN = 1'b0;
        tick(2);
        check("rst_xtstop", bus.XTSTOP, 1);
        check("rst_cpuen", bus.CPUCLKEN, 0);
        check("rst_rtcen", bus.RTCCLKEN, 0);
        check("rst_stable", bus.STABLE, 0);
        check("rst_busy", bus.BUSY, 0);
`ifdef SUBOSC_TIMEOUT_EN
        check("rst_toerr", bus.TOERR, 0);
`endif
        RESET = 1'b0;
        tick(1);
        bus.OSCSELS = 1'b0;
        start_pulse();
        check("start_nosel_xtstop", bus.XTSTOP, 1);
        check("start_nosel_busy", bus.BUSY, 0);
        bus.OSCSELS = 1'b1;
        tick(1);
        start_pulse();
        check("start_xtstop", bus.XTSTOP, 0);
        check("start_busy", bus.BUSY, 1);
        tick(1);
        sub_edges(255);
        check("stab255_stable", bus.STABLE, 0);
        check("stab255_busy", bus.BUSY, 1);
        bus.SUBCKIN = 1'b1;
        tick(2);
        check("edge256_early", bus.STABLE, 0);
        tick(1);
        check("run_stable", bus.STABLE, 1);
        check("run_cpuen", bus.CPUCLKEN, 1);
        check("run_busy", bus.BUSY, 0);
        check("run_xtstop", bus.XTSTOP, 0);
        tick(5);
        bus.SUBCKIN = 1'b0;
        tick(8);
        bus.RTCREQ = 1'b1;
        check("rtc_no_comb", bus.RTCCLKEN, 0);
        tick(1);
        check("rtc_on", bus.RTCCLKEN, 1);
        bus.RTCREQ = 1'b0;
        tick(1);
        check("rtc_off", bus.RTCCLKEN, 0);
        check("rtc_cpuen", bus.CPUCLKEN, 1);
        bus.STOP_REQ = 1'b1;
        tick(1);
        bus.STOP_REQ = 1'b0;
        check("stop_cpuen", bus.CPUCLKEN, 0);
        check("stop_stable", bus.STABLE, 0);
        check("stop_xtstop0", bus.XTSTOP, 0);
        check("stop_busy", bus.BUSY, 1);
        tick(3);
        check("stop_wait_xtstop", bus.XTSTOP, 0);
        check("stop_wait_busy", bus.BUSY, 1);
        tick(1);
        check("stop_done_xtstop", bus.XTSTOP, 1);
        check("stop_done_busy", bus.BUSY, 0);
        start_pulse();
        tick(1);
        sub_edges(3);
        bus.START_REQ = 1'b1;
        bus.STOP_REQ = 1'b1;
        tick(1);
        bus.START_REQ = 1'b0;
        bus.STOP_REQ = 1'b0;
        check("both_busy", bus.BUSY, 1);
        check("both_xtstop", bus.XTSTOP, 0);
        tick(1);
        start_pulse();
        check("stopping_ign_busy", bus.BUSY, 1);
        tick(2);
        check("stopping_end_xtstop", bus.XTSTOP, 1);
        check("stopping_end_busy", bus.BUSY, 0);
        tick(2);
        check("stays_off", bus.XTSTOP, 1);
        start_pulse();
        tick(1);
        sub_edges(100);
        bus.OSCSELS = 1'b0;
        tick(1);
        check("oscsel_off_xtstop", bus.XTSTOP, 1);
        check("oscsel_off_busy", bus.BUSY, 0);
        bus.OSCSELS = 1'b1;
        tick(1);
        start_pulse();
        bus.STABSEL = 2'd3;
        tick(1);
        sub_edges(255);
        check("restart255_stable", bus.STABLE, 0);
        bus.SUBCKIN = 1'b1;
        tick(3);
        check("restart256_stable", bus.STABLE, 1);
        bus.SUBCKIN = 1'b0;
        tick(8);
        bus.RTCREQ = 1'b1;
        tick(1);
        check("pre_rst_rtcen", bus.RTCCLKEN, 1);
        RESET = 1'b1;
        bus.START_REQ = 1'b1;
        tick(1);
        check("midrst_stable", bus.STABLE, 0);
        check("midrst_cpuen", bus.CPUCLKEN, 0);
        check("midrst_rtcen", bus.RTCCLKEN, 0);
        check("midrst_xtstop", bus.XTSTOP, 1);
        check("midrst_busy", bus.BUSY, 0);
        RESET = 1'b0;
        bus.START_REQ = 1'b0;
        bus.RTCREQ = 1'b0;
        bus.STABSEL = 2'd0;
        tick(1);
`ifdef SUBOSC_TIMEOUT_EN
        start_pulse();
        tick(1);
        tick(999);
        check("to_before", bus.TOERR, 0);
        check("to_before_busy", bus.BUSY, 1);
        tick(1);
        check("to_hit", bus.TOERR, 1);
        check("to_hit_xtstop", bus.XTSTOP, 0);
        check("to_hit_busy", bus.BUSY, 1);
        tick(4);
        check("to_off_xtstop", bus.XTSTOP, 1);
        tick(3);
        check("to_sticky", bus.TOERR, 1);
        RESET = 1'b1;
        tick(1);
        check("to_cleared", bus.TOERR, 0);
        RESET = 1'b0;
        tick(1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
